// File: rtl/dwrr_packet_fifos.sv
// dwrr_packet_fifos: per-channel {cost,data} FIFOs feeding a deficit-weighted
// round-robin arbiter (or plain round-robin when MODE=1) and one registered
// output word.
//
// Output handshake (valid/ready): a word transfers on every clock edge where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, data_out and
// out_chan hold, no grant is issued and the pointer/deficits are frozen.
// out_valid never depends combinationally on out_ready.
module dwrr_packet_fifos #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int QWID     = 8,
  parameter int LWID     = 4,
  parameter int MODE     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQS-1:0]         push,
  input  logic [NUM_REQS*WIDTH-1:0]   flat_data_in,
  input  logic [NUM_REQS*LWID-1:0]    flat_cost_in,
  input  logic [NUM_REQS*QWID-1:0]    quantums,
  input  logic                        out_ready,
  output logic [NUM_REQS-1:0]         full,
  output logic [NUM_REQS-1:0]         empty,
  output logic [NUM_REQS-1:0]         drop_err,
  output logic [NUM_REQS-1:0]         gnt,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            data_out,
  output logic [$clog2(NUM_REQS)-1:0] out_chan
);
  localparam int PW = $clog2(NUM_REQS);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = QWID + 1;
  localparam int SW = DW + 1;
  localparam int EW = LWID + WIDTH;

  logic [EW-1:0]   r_mem [NUM_REQS][DEPTH];
  logic [AW-1:0]   r_wr  [NUM_REQS];
  logic [AW-1:0]   r_rd  [NUM_REQS];
  logic [CW-1:0]   r_cnt [NUM_REQS];
  logic [DW-1:0]   r_def [NUM_REQS];
  logic [PW-1:0]   r_ptr;

  logic [NUM_REQS-1:0] w_acc;
  logic [CW-1:0]   w_cnt_nxt [NUM_REQS];
  logic [LWID-1:0] w_cost_in [NUM_REQS];
  logic [EW-1:0]   w_head;
  logic [QWID-1:0] w_quant;
  logic [DW-1:0]   w_hcost;
  logic [SW-1:0]   w_sum;
  logic [DW-1:0]   w_def_nxt;
  logic [PW-1:0]   w_ptr_inc;
  logic            w_ld;
  logic            w_adv;

  // Push acceptance (a full FIFO still takes a word when it pops the same
  // cycle), next occupancy, and the zero-cost-becomes-one rule.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_acc[i]     = push[i] & (~full[i] | gnt[i]);
      w_cnt_nxt[i] = r_cnt[i];
      if (w_acc[i] && !gnt[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end else if (!w_acc[i] && gnt[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      end
      w_cost_in[i] = flat_cost_in[i*LWID +: LWID];
      if (w_cost_in[i] == '0) begin
        w_cost_in[i] = LWID'(1);
      end
    end
  end

  // FIFO storage write port; no reset needed, occupancy guards every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_acc[i]) begin
        r_mem[i][r_wr[i]] <= {w_cost_in[i], flat_data_in[i*WIDTH +: WIDTH]};
      end
    end
  end

  // FIFO pointers, occupancy, registered flags and sticky drop errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
      full     <= '0;
      empty    <= '1;
      drop_err <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (w_acc[i]) r_wr[i] <= r_wr[i] + 1'b1;
        if (gnt[i])   r_rd[i] <= r_rd[i] + 1'b1;
        r_cnt[i] <= w_cnt_nxt[i];
        full[i]  <= (w_cnt_nxt[i] == CW'(DEPTH));
        empty[i] <= (w_cnt_nxt[i] == '0);
        if (push[i] && !w_acc[i]) drop_err[i] <= 1'b1;
      end
    end
  end

  // One arbitration evaluation of the channel under the pointer per loadable
  // cycle: grant, credit top-up (saturating) or credit clear.
  always_comb begin
    gnt       = '0;
    w_ld      = ~out_valid | out_ready;
    w_head    = r_mem[r_ptr][r_rd[r_ptr]];
    w_quant   = quantums[r_ptr*QWID +: QWID];
    w_hcost   = DW'(w_head[EW-1:WIDTH]);
    w_sum     = {1'b0, r_def[r_ptr]} + SW'(w_quant);
    w_def_nxt = r_def[r_ptr];
    w_adv     = 1'b0;
    w_ptr_inc = (r_ptr == PW'(NUM_REQS - 1)) ? '0 : r_ptr + 1'b1;
    if (w_ld) begin
      if (MODE != 0) begin
        gnt[r_ptr] = ~empty[r_ptr];
        w_adv      = 1'b1;
      end else if (empty[r_ptr] || w_quant == '0) begin
        w_def_nxt = '0;
        w_adv     = 1'b1;
      end else if (w_hcost <= r_def[r_ptr]) begin
        gnt[r_ptr] = 1'b1;
        w_def_nxt  = r_def[r_ptr] - w_hcost;
      end else begin
        w_def_nxt = w_sum[DW] ? '1 : w_sum[DW-1:0];
        w_adv     = 1'b1;
      end
    end
  end

  // Pointer and deficit state; frozen whenever the output is stalled.
  // In round-robin mode the deficits are never written and stay at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      for (int i = 0; i < NUM_REQS; i++) r_def[i] <= '0;
    end else if (w_ld) begin
      if (w_adv) r_ptr <= w_ptr_inc;
      if (MODE == 0) r_def[r_ptr] <= w_def_nxt;
    end
  end

  // Output register: load on a grant, otherwise drain when accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      out_chan  <= '0;
    end else if (|gnt) begin
      out_valid <= 1'b1;
      data_out  <= w_head[WIDTH-1:0];
      out_chan  <= r_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dwrr_packet_fifos.sv
// Bench for dwrr_packet_fifos: a DWRR instance and a round-robin instance
// share one stimulus stream; a queue-based reference model predicts grants,
// flags and the output word stream of each.
module tb_dwrr_packet_fifos;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int D    = 8;
  localparam int QW   = 8;
  localparam int LW   = 4;
  localparam int PW   = 2;
  localparam int EW   = LW + W;
  localparam int DMAX = (1 << (QW + 1)) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    push  = '0;
  logic [N*W-1:0]  fdata = '0;
  logic [N*LW-1:0] fcost = '0;
  logic [N*QW-1:0] fq    = '0;
  logic            ready = 1'b0;

  logic [N-1:0] full0, empty0, drop0, gnt0, full1, empty1, drop1, gnt1;
  logic ov0, ov1;
  logic [W-1:0] dout0, dout1;
  logic [PW-1:0] chan0, chan1;

  always #5 clk = ~clk;

  dwrr_packet_fifos #(.NUM_REQS(N), .WIDTH(W), .DEPTH(D), .QWID(QW), .LWID(LW), .MODE(0)) u_dwrr (
    .clk(clk), .rst(rst), .push(push), .flat_data_in(fdata), .flat_cost_in(fcost),
    .quantums(fq), .out_ready(ready), .full(full0), .empty(empty0), .drop_err(drop0),
    .gnt(gnt0), .out_valid(ov0), .data_out(dout0), .out_chan(chan0));

  dwrr_packet_fifos #(.NUM_REQS(N), .WIDTH(W), .DEPTH(D), .QWID(QW), .LWID(LW), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .push(push), .flat_data_in(fdata), .flat_cost_in(fcost),
    .quantums(fq), .out_ready(ready), .full(full1), .empty(empty1), .drop_err(drop1),
    .gnt(gnt1), .out_valid(ov1), .data_out(dout1), .out_chan(chan1));

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (index 0 = DWRR, 1 = round-robin) ----------------
  logic [EW-1:0]   mq [2][N][$];
  int              mdef [2][N];
  int              mptr [2];
  bit              mov [2];
  logic [N-1:0]    mdrop [2];
  logic [PW+W-1:0] exp_q [2][$];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        mq[m][i].delete();
        mdef[m][i] = 0;
      end
      mptr[m]  = 0;
      mov[m]   = 1'b0;
      mdrop[m] = '0;
      exp_q[m].delete();
    end
  endtask

  task automatic model_step(int m, logic [N-1:0] g_act, logic [N-1:0] f_act,
                            logic [N-1:0] e_act, logic [N-1:0] d_act, logic ov_act);
    int p, g, c, q;
    logic [N-1:0] f_exp, e_exp, g_exp;
    logic [EW-1:0] ent;
    logic [LW-1:0] cst;
    p = mptr[m];
    g = -1;
    for (int i = 0; i < N; i++) begin
      f_exp[i] = (mq[m][i].size() == D);
      e_exp[i] = (mq[m][i].size() == 0);
    end
    chk($sformatf("m%0d full", m), f_act, f_exp);
    chk($sformatf("m%0d empty", m), e_act, e_exp);
    chk($sformatf("m%0d drop_err", m), d_act, mdrop[m]);
    chk($sformatf("m%0d out_valid", m), ov_act, mov[m]);
    if (!mov[m] || ready) begin
      q = int'(fq[p*QW +: QW]);
      if (m == 1) begin
        if (mq[m][p].size() != 0) g = p;
        mptr[m] = (p + 1) % N;
      end else if (mq[m][p].size() == 0 || q == 0) begin
        mdef[m][p] = 0;
        mptr[m] = (p + 1) % N;
      end else begin
        ent = mq[m][p][0];
        c = int'(ent[EW-1:W]);
        if (c <= mdef[m][p]) begin
          g = p;
          mdef[m][p] -= c;
        end else begin
          mdef[m][p] = (mdef[m][p] + q > DMAX) ? DMAX : mdef[m][p] + q;
          mptr[m] = (p + 1) % N;
        end
      end
    end
    g_exp = (g >= 0) ? (N'(1) << g) : '0;
    chk($sformatf("m%0d gnt", m), g_act, g_exp);
    if (g >= 0) begin
      ent = mq[m][g].pop_front();
      exp_q[m].push_back({PW'(g), ent[W-1:0]});
      mov[m] = 1'b1;
    end else if (mov[m] && ready) begin
      mov[m] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        if (mq[m][i].size() < D || g == i) begin
          cst = fcost[i*LW +: LW];
          if (cst == '0) cst = LW'(1);
          mq[m][i].push_back({cst, fdata[i*W +: W]});
        end else begin
          mdrop[m][i] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      model_step(0, gnt0, full0, empty0, drop0, ov0);
      model_step(1, gnt1, full1, empty1, drop1, ov1);
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit              stall [2];
  logic [W-1:0]    hd [2];
  logic [PW-1:0]   hc [2];
  bit              rec = 1'b0;
  logic [PW+W-1:0] obs [$];

  task automatic mon(int m, logic ov, logic [W-1:0] d, logic [PW-1:0] ch);
    logic [PW+W-1:0] e;
    if (stall[m]) begin
      chk($sformatf("m%0d held_data", m), d, hd[m]);
      chk($sformatf("m%0d held_chan", m), ch, hc[m]);
    end
    stall[m] = ov && !ready;
    hd[m] = d;
    hc[m] = ch;
    if (ov && ready) begin
      checks++;
      if (exp_q[m].size() == 0) begin
        errors++;
        $display("FAIL m%0d unexpected_word actual=%0h/%0h required=none", m, ch, d);
      end else begin
        e = exp_q[m].pop_front();
        if ({ch, d} !== e) begin
          errors++;
          $display("FAIL m%0d out_word actual=%0h/%0h required=%0h/%0h", m, ch, d, e[PW+W-1:W], e[W-1:0]);
        end
        if (m == 0 && rec) obs.push_back({ch, d});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon(0, ov0, dout0, chan0);
      mon(1, ov1, dout1, chan1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_q(int q0, int q1, int q2, int q3);
    fq = {QW'(q3), QW'(q2), QW'(q1), QW'(q0)};
  endtask

  // One cycle pushing the channels in mask; channel i gets data base+16*i.
  task automatic push_cyc(logic [N-1:0] mask, logic [W-1:0] base, logic [LW-1:0] c);
    push = mask;
    for (int i = 0; i < N; i++) begin
      fdata[i*W +: W]   = base + W'(16 * i);
      fcost[i*LW +: LW] = c;
    end
    cyc();
    push = '0;
  endtask

  // ---------------- stimulus ----------------
  int seq [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
  logic [PW+W-1:0] o;

  initial begin
    cyc(3);
    chk("rst out_valid", {ov1, ov0}, 2'b00);
    chk("rst data_out", {dout1, dout0}, 16'h0000);
    chk("rst out_chan", {chan1, chan0}, 4'h0);
    chk("rst empty", {empty1, empty0}, 8'hFF);
    chk("rst full", {full1, full0}, 8'h00);
    chk("rst drop_err", {drop1, drop0}, 8'h00);
    chk("rst gnt", gnt0, 4'h0);

    // DWRR weights 2:1 with six cost-1 words on ch0 and ch1.
    rst = 1'b1;
    ready = 1'b1;
    set_q(2, 1, 0, 0);
    rec = 1'b1;
    cyc(3);
    for (int k = 0; k < 6; k++) push_cyc(4'b0011, W'(k), LW'(1));
    cyc(60);
    rec = 1'b0;
    chk("seq_len", obs.size(), 12);
    for (int k = 0; k < 12 && k < obs.size(); k++) begin
      o = obs[k];
      chk($sformatf("seq[%0d]", k), o[PW+W-1:W], seq[k]);
    end

    // Overfill ch2 with the consumer stalled, then drain.
    obs.delete();
    ready = 1'b0;
    set_q(0, 0, 4, 0);
    for (int k = 0; k < 10; k++) push_cyc(4'b0100, W'(8'h10 + k), LW'(1));
    chk("ovf full2", {full1[2], full0[2]}, 2'b11);
    chk("ovf drop2", {drop1[2], drop0[2]}, 2'b11);
    chk("ovf held word0", {dout1, dout0}, 16'h3030);
    cyc(5);
    chk("stall gnt", {gnt1, gnt0}, 8'h00);
    ready = 1'b1;
    rec = 1'b1;
    cyc(40);
    rec = 1'b0;
    chk("drain_len", obs.size(), 9);
    for (int k = 0; k < 9 && k < obs.size(); k++) begin
      o = obs[k];
      chk($sformatf("drain[%0d]", k), o[W-1:0], 8'h30 + k);
    end

    // Cost 3 against quantum 2: needs two top-ups.
    set_q(2, 0, 0, 0);
    push_cyc(4'b0001, 8'h5A, LW'(3));
    cyc(20);

    // Two words on ch0..ch2, every channel credited.
    set_q(3, 3, 3, 3);
    push_cyc(4'b0111, 8'h01, LW'(1));
    push_cyc(4'b0111, 8'h02, LW'(1));
    cyc(30);

    // Reset while busy and stalled.
    ready = 1'b0;
    for (int k = 0; k < 4; k++) push_cyc(4'b1111, W'(8'h40 + k), LW'(2));
    cyc(10);
    chk("busy out_valid", {ov1, ov0}, 2'b11);
    rst = 1'b0;
    #1;
    chk("arst out_valid", {ov1, ov0}, 2'b00);
    chk("arst empty", {empty1, empty0}, 8'hFF);
    chk("arst drop_err", {drop1, drop0}, 8'h00);
    cyc(2);
    rst = 1'b1;
    ready = 1'b1;
    set_q(1, 1, 1, 1);
    push_cyc(4'b0010, 8'hB3, LW'(1));
    cyc(12);

    // Randomized traffic with changing quantums and consumer stalls.
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) begin
        for (int i = 0; i < N; i++) fq[i*QW +: QW] = QW'($urandom_range(0, 6));
      end
      for (int i = 0; i < N; i++) push[i] = ($urandom_range(0, 9) < 3);
      fdata = 32'($urandom);
      fcost = 16'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    push = '0;
    ready = 1'b1;
    cyc(50);
    chk("end exp_q0", exp_q[0].size(), 0);
    chk("end exp_q1", exp_q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
